fixed_mul_seq: RTL

- Sequential signed fixed-point multiplier for the ODE solver datapath (Q8.8 by default).
- Computes the product terms (e.g. h*f(x,y)) that feed directly into the 16-bit signed adder/subtractor stage.
- Uses an iterative shift-add over operand magnitudes, then saturates to the signed output range.
- Uses a start/busy/done handshake so the solver's control FSM can sequence it.

---
 rtl/fixed_mul_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/fixed_mul_seq.sv
// Sequential signed fixed-point multiplier (Q(WIDTH-FRAC).FRAC).
// Shift-add over operand magnitudes, then sign restore with saturation to WIDTH bits.
module fixed_mul_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic             sign;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sat;

  // Magnitude as unsigned: the most negative value maps exactly to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  // Returns {overflow, result}: truncates the magnitude, reapplies sign, clamps.
  function automatic logic [WIDTH:0] saturate(input logic neg, input logic [PW-1:0] p);
    logic [PW-1:0] q;
    logic [PW-1:0] maxp;
    logic [PW-1:0] maxn;
    q    = p >> FRAC;
    maxp = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    maxn = maxp + 1'b1;
    if (!neg) begin
      if (q > maxp) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      else          return {1'b0, q[WIDTH-1:0]};
    end else begin
      if (q > maxn) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else          return {1'b0, ~q[WIDTH-1:0] + 1'b1};
    end
  endfunction

  assign sat = saturate(sign, acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      sign     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // Capture operands; later changes on A/B have no effect.
        IDLE: begin
          if (start) begin
            sign   <= A[WIDTH-1] ^ B[WIDTH-1];
            mcand  <= {{WIDTH{1'b0}}, mag(A)};
            mplier <= mag(B);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        // One multiplier bit per cycle, exactly WIDTH iterations.
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        // Scale, sign and clamp the full product; one-cycle done pulse.
        FIN: begin
          result   <= sat[WIDTH-1:0];
          overflow <= sat[WIDTH];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
